// File: rtl/regbank_arb.sv
// ============================================================================
// Module   : regbank_arb
// Brief    : Round-robin arbiter/sequencer sharing one register bank among
//            NREQ requesters. Define REGBANK_ARB_ERR_EN to add the err_o port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_arb #(
    parameter int NREQ = 4,
    parameter int NREG = 4,
    parameter int AW   = 2,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      we_i,
    input  logic [NREQ-1:0]      clr_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    input  logic [NREQ*DW-1:0]   wdata_i,
    output logic [NREQ-1:0]      ack_o,
`ifdef REGBANK_ARB_ERR_EN
    output logic [NREQ-1:0]      err_o,
`endif
    output logic [DW-1:0]        rdata_o,
    output logic [NREG-1:0]      reg_wen_o,
    output logic [NREG-1:0]      reg_clr_o,
    output logic [NREG-1:0]      reg_ren_o,
    output logic [DW-1:0]        reg_wdata_o,
    input  logic [NREG*DW-1:0]   reg_rdata_i
);

    localparam int            IW      = $clog2(NREQ);
    localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [IW-1:0]   gnt_q,   gnt_d;
    logic            we_q,    we_d;
    logic            clr_q,   clr_d;
    logic            oor_q,   oor_d;
    logic [NREQ-1:0] ack_q,   ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0] wen_q,   wen_d;
    logic [NREG-1:0] clrs_q,  clrs_d;
    logic [NREG-1:0] ren_q,   ren_d;
`ifdef REGBANK_ARB_ERR_EN
    logic [NREQ-1:0] err_q,   err_d;
`endif

    logic            arb_found;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   arb_cand;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic            win_we;
    logic            win_clr;
    logic            win_oor;
    logic [NREG-1:0] win_sel;
    logic [DW-1:0]   rd_or;
    logic [NREQ-1:0] gnt_onehot;

    // Search starts one past the last winner, so the last winner ends up last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            arb_cand = IW'((int'(ptr_q) + i) % NREQ);
            if (!arb_found && req_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        win_clr   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_idx == IW'(k)) begin
                win_addr  = addr_i[k*AW +: AW];
                win_wdata = wdata_i[k*DW +: DW];
                win_we    = we_i[k];
                win_clr   = clr_i[k];
            end
        end
        win_oor = ({1'b0, win_addr} >= (AW+1)'(NREG));
        win_sel = '0;
        for (int r = 0; r < NREG; r++) begin
            win_sel[r] = (win_addr == AW'(r));
        end
    end

    always_comb begin
        rd_or = '0;
        for (int r = 0; r < NREG; r++) begin
            rd_or = rd_or | reg_rdata_i[r*DW +: DW];
        end
        gnt_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            gnt_onehot[k] = (gnt_q == IW'(k));
        end
    end

    // All outputs are registered: strobes are set on entry to ACCESS, ack on entry to ACK.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        clr_d   = clr_q;
        oor_d   = oor_q;
        ack_d   = '0;
        rdata_d = '0;
        wdata_d = '0;
        wen_d   = '0;
        clrs_d  = '0;
        ren_d   = '0;
`ifdef REGBANK_ARB_ERR_EN
        err_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    gnt_d   = arb_idx;
                    ptr_d   = arb_idx;
                    we_d    = win_we;
                    clr_d   = win_clr;
                    oor_d   = win_oor;
                    wdata_d = win_wdata;
                    if (win_clr) begin
                        clrs_d = win_sel;
                    end else if (win_we) begin
                        wen_d  = win_sel;
                    end else begin
                        ren_d  = win_sel;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!clr_q && !we_q && !oor_q) begin
                    rdata_d = rd_or;
                end
                ack_d = gnt_onehot;
`ifdef REGBANK_ARB_ERR_EN
                err_d = oor_q ? gnt_onehot : '0;
`endif
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            clr_q   <= 1'b0;
            oor_q   <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            wen_q   <= '0;
            clrs_q  <= '0;
            ren_q   <= '0;
`ifdef REGBANK_ARB_ERR_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            clr_q   <= clr_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            clrs_q  <= clrs_d;
            ren_q   <= ren_d;
`ifdef REGBANK_ARB_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign reg_wen_o   = wen_q;
    assign reg_clr_o   = clrs_q;
    assign reg_ren_o   = ren_q;
    assign reg_wdata_o = wdata_q;
`ifdef REGBANK_ARB_ERR_EN
    assign err_o       = err_q;
`endif

endmodule

`default_nettype wire
